// File: rtl/flip_scan_controller.sv
// rtl/flip_scan_controller.sv - row scan sequencer deciding per-row flip and patch need
module flip_scan_controller #(
    parameter  int N  = 16,
    parameter  int M  = 16,
    localparam int AW = $clog2(M),
    localparam int CW = $clog2(N + 1),
    localparam int TW = $clog2(M * N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    input  logic [N-1:0]  rd_mask,
    input  logic [N-1:0]  rd_stuck,
    output logic [M-1:0]  flip,
    output logic [M-1:0]  patch_need,
    output logic [TW-1:0] err_total
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;
    logic [M-1:0]  flip_q, flip_d;
    logic [M-1:0]  patch_q, patch_d;
    logic [TW-1:0] err_q, err_d;

    logic          accept;
    logic [N-1:0]  conf;
    logic [CW-1:0] c0, c1, m_cnt, res;

    // A start landing on the DONE cycle is taken too, so scans can run back to back.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = start ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        rd_en = (state_q == S_ISSUE);
        done  = (state_q == S_DONE);
    end

    // Conflicts if stored as-is (c0) versus inverted (c1) for the row returned this cycle.
    always_comb begin
        conf  = (rd_data ^ rd_stuck) & rd_mask;
        c0    = '0;
        m_cnt = '0;
        for (int i = 0; i < N; i++) begin
            c0    = c0 + CW'(conf[i]);
            m_cnt = m_cnt + CW'(rd_mask[i]);
        end
        c1  = m_cnt - c0;
        res = (c0 > c1) ? c1 : c0;
    end

    always_comb begin
        addr_d  = addr_q;
        flip_d  = flip_q;
        patch_d = patch_q;
        err_d   = err_q;
        if (accept) begin
            addr_d  = '0;
            flip_d  = '0;
            patch_d = '0;
            err_d   = '0;
        end else begin
            if ((state_q == S_ISSUE) && (addr_q != LAST_ADDR)) begin
                addr_d = addr_q + AW'(1);
            end
            if (pend_q) begin
                flip_d[pend_addr_q]  = (c0 > c1);
                patch_d[pend_addr_q] = (res != '0);
                err_d                = err_q + TW'(res);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            flip_q      <= '0;
            patch_q     <= '0;
            err_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            pend_q      <= (state_q == S_ISSUE);
            pend_addr_q <= addr_q;
            flip_q      <= flip_d;
            patch_q     <= patch_d;
            err_q       <= err_d;
        end
    end

    assign rd_addr    = addr_q;
    assign flip       = flip_q;
    assign patch_need = patch_q;
    assign err_total  = err_q;

endmodule
